if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, directly upstream of the ID stage. It holds the program counter, reads the instruction ROM, and drives the IF/ID pipeline register that feeds ID's `instruction`, `PCIn` and `flushIn` inputs. It accepts a branch redirect from EXE and a freeze from the hazard unit.

---
 rtl/if_stage_pkg.sv | 27 ++
 rtl/if_stage_inst_mem.sv | 26 ++
 rtl/if_stage.sv | 59 +++++
 tb/tb_if_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared pipeline widths, opcodes and the built-in boot image
package if_stage_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   // Opcode field values, shared with the ID controller
   localparam logic [5:0] OP_NOP = 6'b000000;
   localparam logic [5:0] OP_ADD = 6'b000001;
   localparam logic [5:0] OP_SUB = 6'b000011;
   localparam logic [5:0] OP_AND = 6'b000101;
   localparam logic [5:0] OP_OR  = 6'b000110;
   localparam logic [5:0] OP_LD  = 6'b100100;
   localparam logic [5:0] OP_ST  = 6'b100101;
   localparam logic [5:0] OP_BEZ = 6'b101000;
   localparam logic [5:0] OP_BNE = 6'b101001;
   localparam logic [5:0] OP_JMP = 6'b101010;

   // Contents of program.hex, compiled in so the ROM needs no file access;
   // every word is distinct so fetch order is observable
   function automatic logic [INSTR_W-1:0] boot_word(input logic [31:0] idx);
      return 32'h0422_0800 + idx * 32'h0001_0001;
   endfunction

endpackage

// File: rtl/if_stage_inst_mem.sv
// inst_mem: combinational instruction ROM, word addressed, wrapping modulo depth
module inst_mem
   import if_stage_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter     IMEM_INIT  = "program.hex"
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic [INSTR_W-1:0] data
);

   localparam int AW      = $clog2(IMEM_DEPTH);
   localparam bit BUILTIN = (IMEM_INIT == "program.hex");

   logic [INSTR_W-1:0] rom [IMEM_DEPTH];
   logic               unused_hi;

   // Unknown image names leave the ROM filled with NOPs
   for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
      assign rom[i] = BUILTIN ? boot_word(32'(i)) : NOP_INSTR;
   end

   assign data      = rom[addr[AW-1:0]];
   assign unused_hi = ^addr[ADDR_W-1:AW];

endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, instruction ROM fetch and the IF/ID pipeline register
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                IMEM_DEPTH = 256,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter                    IMEM_INIT  = "program.hex"
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  PCOut,
   output logic               flushOut,
   output logic [ADDR_W-1:0]  pc
);

   logic [ADDR_W-1:0]  pc_plus4, pc_nxt, pco_nxt;
   logic [INSTR_W-1:0] rom_data, ins_nxt;
   logic               fl_nxt;
   logic               unused_ba;

   inst_mem #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .IMEM_INIT  (IMEM_INIT)
   ) u_imem (
      .addr (ADDR_W'(pc[ADDR_W-1:2])),
      .data (rom_data)
   );

   assign pc_plus4  = pc + ADDR_W'(4);
   assign unused_ba = ^branch_addr[1:0];

   // Next-state priority: branch redirect beats freeze, which beats sequential fetch
   always_comb begin
      pc_nxt  = branch_taken ? {branch_addr[ADDR_W-1:2], 2'b00} : freeze ? pc : pc_plus4;
      ins_nxt = branch_taken ? NOP_INSTR : freeze ? instruction : rom_data;
      pco_nxt = branch_taken ? '0 : freeze ? PCOut : pc_plus4;
      fl_nxt  = branch_taken | (freeze & flushOut);
   end

   // PC and IF/ID register, cleared asynchronously on active-low rst
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         instruction <= NOP_INSTR;
         PCOut       <= '0;
         flushOut    <= 1'b0;
      end else begin
         pc          <= pc_nxt;
         instruction <= ins_nxt;
         PCOut       <= pco_nxt;
         flushOut    <= fl_nxt;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench driving directed fetch/freeze/branch/reset vectors
module tb_if_stage;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pco;
      logic        fl;
      logic [31:0] pc;
      string       name;
   } exp_t;

   localparam logic [31:0] R0   = 32'h0422_0800;
   localparam logic [31:0] R1   = 32'h0423_0801;
   localparam logic [31:0] R2   = 32'h0424_0802;
   localparam logic [31:0] R3   = 32'h0425_0803;
   localparam logic [31:0] R4   = 32'h0426_0804;
   localparam logic [31:0] R8   = 32'h042A_0808;
   localparam logic [31:0] R16  = 32'h0432_0810;
   localparam logic [31:0] R17  = 32'h0433_0811;
   localparam logic [31:0] R255 = 32'h0521_08FF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = '0;
   logic [31:0] instruction, PCOut, pc;
   logic        flushOut;

   exp_t exp_q [$];
   exp_t e;
   int   total = 0;
   int   passed = 0;

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .instruction  (instruction),
      .PCOut        (PCOut),
      .flushOut     (flushOut),
      .pc           (pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   task automatic drive(input logic fr, input logic bt, input logic [31:0] ba,
                        input logic [31:0] ins, input logic [31:0] pco,
                        input logic fl, input logic [31:0] npc, input string n);
      freeze       = fr;
      branch_taken = bt;
      branch_addr  = ba;
      exp_q.push_back('{ins: ins, pco: pco, fl: fl, pc: npc, name: n});
   endtask

   task automatic step(input logic fr, input logic bt, input logic [31:0] ba,
                       input logic [31:0] ins, input logic [31:0] pco,
                       input logic fl, input logic [31:0] npc, input string n);
      @(negedge clk);
      drive(fr, bt, ba, ins, pco, fl, npc, n);
   endtask

   // Monitor: one expectation per clock edge, compared just after the edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.name, ".instruction"}, instruction, e.ins);
         chk({e.name, ".PCOut"}, PCOut, e.pco);
         chk({e.name, ".flushOut"}, 32'(flushOut), 32'(e.fl));
         chk({e.name, ".pc"}, pc, e.pc);
      end
   end

   initial begin
      #1;
      chk("por.pc", pc, 32'h0);
      chk("por.instruction", instruction, 32'h0);
      chk("por.PCOut", PCOut, 32'h0);
      chk("por.flushOut", 32'(flushOut), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, R0, 32'd4, 0, 32'd4, "seq0");
      step(0, 0, 0, R1, 32'd8, 0, 32'd8, "seq1");
      step(1, 0, 0, R1, 32'd8, 0, 32'd8, "frz1");
      step(1, 0, 0, R1, 32'd8, 0, 32'd8, "frz2");
      step(0, 0, 0, R2, 32'd12, 0, 32'd12, "seq2");
      step(0, 0, 0, R3, 32'd16, 0, 32'd16, "seq3");
      step(0, 0, 0, R4, 32'd20, 0, 32'd20, "seq4");
      step(0, 1, 32'h40, 32'h0, 32'h0, 1, 32'h40, "br40");
      step(0, 0, 0, R16, 32'h44, 0, 32'h44, "tgt16");
      step(0, 0, 0, R17, 32'h48, 0, 32'h48, "tgt17");
      step(1, 1, 32'h23, 32'h0, 32'h0, 1, 32'h20, "brfrz");
      step(1, 0, 0, 32'h0, 32'h0, 1, 32'h20, "bubhold1");
      step(1, 0, 0, 32'h0, 32'h0, 1, 32'h20, "bubhold2");
      step(0, 0, 0, R8, 32'h24, 0, 32'h24, "tgt8");
      step(0, 1, 32'h3FC, 32'h0, 32'h0, 1, 32'h3FC, "br3fc");
      step(0, 0, 0, R255, 32'h400, 0, 32'h400, "wrap255");
      step(0, 0, 0, R0, 32'h404, 0, 32'h404, "wrap0");
      step(0, 0, 0, R1, 32'h408, 0, 32'h408, "wrap1");
      step(0, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, "brtop");
      step(0, 0, 0, R255, 32'h0, 0, 32'h0, "pcovf");
      step(0, 0, 0, R0, 32'h4, 0, 32'h4, "postovf");
      @(negedge clk);
      freeze       = 1'b1;
      branch_taken = 1'b1;
      branch_addr  = 32'h80;
      #2 rst = 1'b0;
      #1;
      chk("midrst.pc", pc, 32'h0);
      chk("midrst.instruction", instruction, 32'h0);
      chk("midrst.PCOut", PCOut, 32'h0);
      chk("midrst.flushOut", 32'(flushOut), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, R0, 32'd4, 0, 32'd4, "rel0");
      step(0, 0, 0, R1, 32'd8, 0, 32'd8, "rel1");
      repeat (2) @(negedge clk);
      chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
